fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares the single write port of the SRAM-backed stream FIFO between NUM_REQ AXI-stream-style requesters.
- Sits directly in front of the FIFO: drives its w_vld/data_in and consumes its w_rdy.
- Holds a grant until the requester signals last or a burst limit is reached, so FIFO contents stay packet-contiguous per source.
- Exposes the current grant for upstream/debug tagging.

Parameters:
- WIDTH, 45, data width per requester and toward the FIFO.
- NUM_REQ, 4, number of requesters, 2..8.
- MAX_BURST, 16, maximum beats per grant, 1..256.
- ID_W (localparam), $clog2(NUM_REQ), grant index width.

Ports:
- axis_clk  in  1  single clock.
- axi_reset  in  1  synchronous, active-high reset.
- s_vld  in  NUM_REQ  per-requester valid.
- s_rdy  out  NUM_REQ  per-requester ready.
- s_last  in  NUM_REQ  per-requester end-of-packet, qualified by s_vld.
- s_data  in  NUM_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- w_vld  out  1  write valid to FIFO.
- w_rdy  in  1  FIFO ready (deasserts when full).
- data_out  out  WIDTH  write data to FIFO data_in.
- grant_vld  out  1  a grant is active.
- grant_id  out  ID_W  index of the granted requester.

Behaviour:
- Clocking and reset: one clock, axis_clk. Reset is synchronous, active-high (axi_reset sampled on the axis_clk rising edge).
- Reset values: state=IDLE, grant_id=0, last_grant=NUM_REQ-1 (channel 0 has first priority), beat_cnt=0, grant_vld=0, w_vld=0, s_rdy=all 0.
- data_out is don't-care while w_vld=0, but must be deterministic.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any s_vld is set, pick the first set bit searching upward from last_grant+1, wrapping mod NUM_REQ.
  - Register that index into grant_id, clear beat_cnt, go to GRANT.
  - Otherwise stay in IDLE.
  - In IDLE, w_vld=0 and s_rdy=0.
- GRANT (g = grant_id):
  - grant_vld=1.
  - w_vld = s_vld[g] and data_out = s_data[g], both combinational.
  - s_rdy[g] = w_rdy; all other s_rdy bits = 0.
  - A beat occurs when s_vld[g] & w_rdy.
- Grant release:
  - Release on a beat with s_last[g]=1, or on a beat with beat_cnt == MAX_BURST-1.
  - On release: next state IDLE, last_grant <= g, beat_cnt <= 0.
  - Otherwise, each beat increments beat_cnt.
  - beat_cnt width is $clog2(MAX_BURST+1) and never wraps.
- Latency and throughput:
  - Arbitration latency: 1 cycle from s_vld in IDLE to grant_vld.
  - One mandatory IDLE bubble cycle between consecutive grants.
  - Peak throughput: MAX_BURST beats per MAX_BURST+1 cycles.
- Hold while granted: if s_vld[g] drops, the grant is held indefinitely; no timeout and no pre-emption.
- FIFO full: w_rdy=0 stalls the granted requester only. beat_cnt and state hold. Handshake signals to the FIFO must not change except through s_vld[g].
- Simultaneous requests: the round-robin guarantees every continuously-requesting channel is granted within NUM_REQ grants.
- A requester whose s_vld falls in IDLE before selection is simply not chosen; there is no memory of past requests.
- s_last outside a beat is ignored.
- Reset mid-operation: in-flight grant is abandoned; all outputs return to reset values on the next edge. No partial beat is produced because w_vld is combinational from the state.
- MAX_BURST=1 forces a release after every beat, giving beat-level round-robin.

Test Plan:
- Single requester: after reset, s_vld[2]=1 and w_rdy=1 constant, 5 beats with last on the 5th. Expect grant_vld/grant_id=2 one cycle after s_vld, 5 consecutive w_vld beats with data_out = s_data[2], then 1 IDLE cycle.
- Round-robin fairness: all 4 requesters valid, each packet 3 beats. Grant order 0,1,2,3,0; each grant exactly 3 beats; each grant followed by 1 bubble cycle.
- Burst limit: MAX_BURST=16, requester 1 sends a 40-beat packet with requester 3 also valid. Expect grants 1(16 beats), 3(its packet), 1(16), 3, then 1(8).
- Backpressure: w_rdy toggles 1,0,0,1 repeating during a 6-beat grant. s_rdy[g] mirrors w_rdy, no beat is lost or duplicated, beat_cnt reaches 5 at the last beat, other s_rdy bits stay 0.
- Granted requester stalls: s_vld[g] drops for 10 cycles mid-packet while others are valid. grant_id is unchanged, w_vld=0 for those cycles, and the packet resumes and completes on the same grant.
- Reset mid-grant: assert axi_reset for 1 cycle during beat 2 of a grant to channel 3. Next cycle grant_vld=0, w_vld=0, s_rdy=0. On the next request, channel 0 has priority (last_grant=3).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port between
// NUM_REQ stream requesters; a grant is held until last or the burst limit.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 45,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                       axis_clk,
    input  logic                       axi_reset,
    input  logic [NUM_REQ-1:0]         s_vld,
    output logic [NUM_REQ-1:0]         s_rdy,
    input  logic [NUM_REQ-1:0]         s_last,
    input  logic [NUM_REQ*WIDTH-1:0]   s_data,
    output logic                       w_vld,
    input  logic                       w_rdy,
    output logic [WIDTH-1:0]           data_out,
    output logic                       grant_vld,
    output logic [ID_W-1:0]            grant_id
);

    localparam int BC_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]      state;
    logic [ID_W-1:0] last_grant;
    logic [BC_W-1:0] beat_cnt;

    logic            sel_vld;
    logic [ID_W-1:0] sel_id;
    logic [ID_W:0]   cand_w;
    logic [ID_W-1:0] cand;
    logic            beat;
    logic            release_grant;
    logic [WIDTH-1:0] data_mux;

    // Search upward from the channel after the last winner, wrapping, so the
    // most recently served channel ends up with the lowest priority.
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = '0;
        cand_w  = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_w = {1'b0, last_grant} + (ID_W+1)'(k);
            if (cand_w >= (ID_W+1)'(NUM_REQ)) begin
                cand_w = cand_w - (ID_W+1)'(NUM_REQ);
            end
            cand = cand_w[ID_W-1:0];
            if (!sel_vld && s_vld[cand]) begin
                sel_vld = 1'b1;
                sel_id  = cand;
            end
        end
    end

    always_comb begin
        data_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_id) begin
                data_mux = s_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Write-side handshake is purely combinational from the registered grant,
    // so a reset can never leave a half-issued beat behind.
    always_comb begin
        s_rdy = '0;
        if (state == GRANT) begin
            s_rdy[grant_id] = w_rdy;
        end
    end

    assign grant_vld     = (state == GRANT);
    assign w_vld         = grant_vld && s_vld[grant_id];
    assign data_out      = grant_vld ? data_mux : '0;
    assign beat          = w_vld && w_rdy;
    assign release_grant = beat && (s_last[grant_id] ||
                                    (beat_cnt == BC_W'(MAX_BURST - 1)));

    always_ff @(posedge axis_clk) begin
        if (axi_reset) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        grant_id <= sel_id;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        state      <= IDLE;
                        last_grant <= grant_id;
                        beat_cnt   <= '0;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + BC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a small per-requester packet model drives
// the stream inputs, and each scenario task checks hand-derived grant sequences.
module tb_fifo_wr_arbiter;

    localparam int WIDTH     = 45;
    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 16;

    logic                     axis_clk = 1'b0;
    logic                     axi_reset;
    logic [NUM_REQ-1:0]       s_vld;
    logic [NUM_REQ-1:0]       s_rdy;
    logic [NUM_REQ-1:0]       s_last;
    logic [NUM_REQ*WIDTH-1:0] s_data;
    logic                     w_vld;
    logic                     w_rdy;
    logic [WIDTH-1:0]         data_out;
    logic                     grant_vld;
    logic [1:0]               grant_id;

    int checks   = 0;
    int failures = 0;

    int   pkt_len [NUM_REQ];
    int   sent    [NUM_REQ];
    int   tot     [NUM_REQ];
    int   pkts    [NUM_REQ];
    bit   hold    [NUM_REQ];
    bit   rst;
    logic [NUM_REQ-1:0] hs = '0;

    fifo_wr_arbiter #(
        .WIDTH     (WIDTH),
        .NUM_REQ   (NUM_REQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .axis_clk  (axis_clk),
        .axi_reset (axi_reset),
        .s_vld     (s_vld),
        .s_rdy     (s_rdy),
        .s_last    (s_last),
        .s_data    (s_data),
        .w_vld     (w_vld),
        .w_rdy     (w_rdy),
        .data_out  (data_out),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    always #5 axis_clk = ~axis_clk;

    // Each beat carries its requester index and a running beat number, so lost
    // or duplicated beats show up as a data mismatch.
    function automatic logic [WIDTH-1:0] lane(input int i, input int n);
        return {5'(i), 40'(n)};
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            s_vld[i]  = (pkts[i] > 0) && !hold[i];
            s_last[i] = s_vld[i] && (sent[i] == pkt_len[i] - 1);
            s_data[i*WIDTH +: WIDTH] = lane(i, tot[i]);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_REQ; i++) begin
            pkt_len[i] = 1;
            sent[i]    = 0;
            tot[i]     = 0;
            pkts[i]    = 0;
            hold[i]    = 1'b0;
        end
        hs = '0;
    endtask

    // Advance one cycle: retire the handshakes seen last cycle, drive new inputs
    // just after the edge, then sample mid-cycle.
    task automatic step(input logic rdy);
        @(posedge axis_clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs[i]) begin
                tot[i]++;
                sent[i]++;
                if (sent[i] == pkt_len[i]) begin
                    sent[i] = 0;
                    pkts[i]--;
                end
            end
        end
        axi_reset = rst;
        w_rdy     = rdy;
        drive();
        #3;
        hs = s_vld & s_rdy;
    endtask

    task automatic do_reset();
        clear_model();
        rst = 1'b1;
        step(1'b1);
        step(1'b1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_model();
        rst = 1'b1;
        step(1'b0);
        step(1'b0);
        checks++;
        if ({grant_vld, w_vld, s_rdy, grant_id} !== 8'b0) begin
            failures++;
            $display("[TB] FAIL reset_state got=%b exp=%b",
                     {grant_vld, w_vld, s_rdy, grant_id}, 8'b0);
        end
        rst = 1'b0;
        step(1'b1);
        checks++;
        if ({grant_vld, w_vld, s_rdy} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle_no_req got=%b exp=%b",
                     {grant_vld, w_vld, s_rdy}, 6'b0);
        end
    endtask

    task automatic test_single();
        do_reset();
        pkts[2]    = 1;
        pkt_len[2] = 5;
        step(1'b1);
        checks++;
        if ({grant_vld, w_vld, s_rdy} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL single_arb_cycle got=%b exp=%b", {grant_vld, w_vld, s_rdy}, 6'b0);
        end
        for (int b = 0; b < 5; b++) begin
            step(1'b1);
            checks++;
            if ({grant_vld, grant_id, w_vld, s_rdy} !== {1'b1, 2'd2, 1'b1, 4'b0100}) begin
                failures++;
                $display("[TB] FAIL single_grant beat=%0d got=%b exp=%b", b,
                         {grant_vld, grant_id, w_vld, s_rdy}, {1'b1, 2'd2, 1'b1, 4'b0100});
            end
            checks++;
            if (data_out !== lane(2, b)) begin
                failures++;
                $display("[TB] FAIL single_data beat=%0d got=%h exp=%h", b, data_out, lane(2, b));
            end
        end
        step(1'b1);
        checks++;
        if ({grant_vld, w_vld, s_rdy} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL single_bubble got=%b exp=%b", {grant_vld, w_vld, s_rdy}, 6'b0);
        end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        int exp_tot [NUM_REQ] = '{default: 0};
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            pkts[i]    = (i == 0) ? 2 : 1;
            pkt_len[i] = 3;
        end
        step(1'b1);
        checks++;
        if ({grant_vld, w_vld} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL rr_arb_cycle got=%b exp=00", {grant_vld, w_vld});
        end
        for (int n = 0; n < 5; n++) begin
            for (int b = 0; b < 3; b++) begin
                step(1'b1);
                checks++;
                if ({grant_vld, grant_id, w_vld, s_rdy} !==
                    {1'b1, 2'(order[n]), 1'b1, 4'(1 << order[n])}) begin
                    failures++;
                    $display("[TB] FAIL rr_grant n=%0d beat=%0d got=%b exp=%b", n, b,
                             {grant_vld, grant_id, w_vld, s_rdy},
                             {1'b1, 2'(order[n]), 1'b1, 4'(1 << order[n])});
                end
                checks++;
                if (data_out !== lane(order[n], exp_tot[order[n]])) begin
                    failures++;
                    $display("[TB] FAIL rr_data n=%0d beat=%0d got=%h exp=%h", n, b,
                             data_out, lane(order[n], exp_tot[order[n]]));
                end
                exp_tot[order[n]]++;
            end
            step(1'b1);
            checks++;
            if ({grant_vld, w_vld, s_rdy} !== 6'b0) begin
                failures++;
                $display("[TB] FAIL rr_bubble n=%0d got=%b exp=%b", n, {grant_vld, w_vld, s_rdy}, 6'b0);
            end
        end
    endtask

    task automatic test_burst_limit();
        int ids   [5] = '{1, 3, 1, 3, 1};
        int beats [5] = '{16, 4, 16, 4, 8};
        int exp_tot [NUM_REQ] = '{default: 0};
        do_reset();
        pkts[1] = 1;  pkt_len[1] = 40;
        pkts[3] = 2;  pkt_len[3] = 4;
        step(1'b1);
        for (int n = 0; n < 5; n++) begin
            for (int b = 0; b < beats[n]; b++) begin
                step(1'b1);
                checks++;
                if ({grant_vld, grant_id, w_vld} !== {1'b1, 2'(ids[n]), 1'b1} ||
                    data_out !== lane(ids[n], exp_tot[ids[n]])) begin
                    failures++;
                    $display("[TB] FAIL burst_beat n=%0d beat=%0d got=%b/%h exp=%b/%h", n, b,
                             {grant_vld, grant_id, w_vld}, data_out,
                             {1'b1, 2'(ids[n]), 1'b1}, lane(ids[n], exp_tot[ids[n]]));
                end
                exp_tot[ids[n]]++;
            end
            step(1'b1);
            checks++;
            if ({grant_vld, w_vld} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL burst_release n=%0d got=%b exp=00", n, {grant_vld, w_vld});
            end
        end
    endtask

    task automatic test_backpressure();
        int   done = 0;
        logic r;
        do_reset();
        pkts[0]    = 1;
        pkt_len[0] = 6;
        step(1'b1);
        for (int j = 0; j < 12; j++) begin
            r = ((j % 4) == 0) || ((j % 4) == 3);
            step(r);
            checks++;
            if ({grant_vld, grant_id, w_vld, s_rdy} !== {1'b1, 2'd0, 1'b1, 3'b000, r} ||
                data_out !== lane(0, done)) begin
                failures++;
                $display("[TB] FAIL bp_cycle j=%0d got=%b/%h exp=%b/%h", j,
                         {grant_vld, grant_id, w_vld, s_rdy}, data_out,
                         {1'b1, 2'd0, 1'b1, 3'b000, r}, lane(0, done));
            end
            checks++;
            if (dut.beat_cnt !== 5'(done)) begin
                failures++;
                $display("[TB] FAIL bp_beat_cnt j=%0d got=%0d exp=%0d", j, dut.beat_cnt, done);
            end
            if (r) done++;
        end
        step(1'b1);
        checks++;
        if ({grant_vld, w_vld, s_rdy} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL bp_release got=%b exp=%b", {grant_vld, w_vld, s_rdy}, 6'b0);
        end
    endtask

    task automatic test_stall();
        int done = 0;
        bit h;
        do_reset();
        pkts[1] = 1;  pkt_len[1] = 6;
        pkts[2] = 1;  pkt_len[2] = 2;
        pkts[3] = 1;  pkt_len[3] = 2;
        step(1'b1);
        for (int c = 0; c < 16; c++) begin
            hold[1] = (c >= 3) && (c < 13);
            h = hold[1];
            step(1'b1);
            checks++;
            if ({grant_vld, grant_id, w_vld, s_rdy} !== {1'b1, 2'd1, ~h, 4'b0010}) begin
                failures++;
                $display("[TB] FAIL stall_hold c=%0d got=%b exp=%b", c,
                         {grant_vld, grant_id, w_vld, s_rdy}, {1'b1, 2'd1, ~h, 4'b0010});
            end
            if (!h) begin
                checks++;
                if (data_out !== lane(1, done)) begin
                    failures++;
                    $display("[TB] FAIL stall_data c=%0d got=%h exp=%h", c, data_out, lane(1, done));
                end
                done++;
            end
        end
        hold[1] = 1'b0;
        step(1'b1);
        for (int g = 2; g < 4; g++) begin
            for (int b = 0; b < 2; b++) begin
                step(1'b1);
                checks++;
                if ({grant_vld, grant_id, w_vld} !== {1'b1, 2'(g), 1'b1}) begin
                    failures++;
                    $display("[TB] FAIL stall_others g=%0d got=%b exp=%b", g,
                             {grant_vld, grant_id, w_vld}, {1'b1, 2'(g), 1'b1});
                end
            end
            step(1'b1);
        end
    endtask

    task automatic test_reset_mid();
        pkts[1] = 1;  pkt_len[1] = 1;  sent[1] = 0;
        step(1'b1);
        step(1'b1);
        checks++;
        if ({grant_vld, grant_id, w_vld} !== {1'b1, 2'd1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL rstmid_pre_grant got=%b exp=%b", {grant_vld, grant_id, w_vld}, 4'b1011);
        end
        pkts[3] = 1;  pkt_len[3] = 6;  sent[3] = 0;
        step(1'b1);
        for (int c = 0; c < 3; c++) begin
            rst = (c == 2);
            step(1'b1);
            checks++;
            if ({grant_vld, grant_id, w_vld} !== {1'b1, 2'd3, 1'b1}) begin
                failures++;
                $display("[TB] FAIL rstmid_grant3 c=%0d got=%b exp=%b", c,
                         {grant_vld, grant_id, w_vld}, 4'b1111);
            end
        end
        rst = 1'b0;
        pkts[0] = 1;  pkt_len[0] = 2;
        step(1'b1);
        checks++;
        if ({grant_vld, w_vld, s_rdy} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_after_reset got=%b exp=%b", {grant_vld, w_vld, s_rdy}, 6'b0);
        end
        step(1'b1);
        checks++;
        if ({grant_vld, grant_id, w_vld} !== {1'b1, 2'd0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL rstmid_priority got=%b exp=%b", {grant_vld, grant_id, w_vld}, 4'b1001);
        end
    endtask

    initial begin
        axi_reset = 1'b1;
        w_rdy     = 1'b0;
        rst       = 1'b1;
        clear_model();
        drive();
        $display("[TB] starting fifo_wr_arbiter bench");
        test_reset();
        test_single();
        test_round_robin();
        test_burst_limit();
        test_backpressure();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
